// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flip-flop
// resolves one result bit per cycle, LSB first, under a start/busy/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic             load;
    logic             last;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] psum_next;

    // Handshake: start is accepted only from IDLE or DONE (load). busy is high
    // exactly while RUN; done is high for the single DONE cycle that follows.
    always_comb begin
        load      = start && (state == IDLE || state == DONE);
        last      = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
        s         = a_sr[0] ^ b_sr[0] ^ carry;
        c_next    = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        psum_next = {s, psum[WIDTH-1:1]};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with sub.
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            psum  <= psum_next;
            carry <= c_next;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                // On the MSB slice, carry is the carry into the MSB.
                sum  <= psum_next;
                cout <= c_next;
                ovf  <= carry ^ c_next;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH=8 and WIDTH=16: directed and random
// operations, expected results queued at issue and checked on each done pulse.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic [9:0]  exp_q8[$];
    logic [17:0] exp_q16[$];

    int checks = 0;
    int failures = 0;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} for a w-bit add or subtract.
    function automatic logic [65:0] model(input int w, input logic [63:0] x,
                                          input logic [63:0] y, input logic sb);
        logic [64:0] mask, t;
        logic [63:0] s;
        logic        c, sa, sy, ss, v;
        mask = (65'd1 << w) - 65'd1;
        t    = {1'b0, x} + ({1'b0, sb ? ~y : y} & mask) + {64'd0, sb};
        s    = t[63:0] & mask[63:0];
        c    = t[w];
        sa   = x[w-1];
        sy   = y[w-1];
        ss   = s[w-1];
        v    = sb ? ((sa != sy) && (ss != sa)) : ((sa == sy) && (ss != sa));
        return {v, c, s};
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (exp_q8.size() == 0) begin
                check("done8_unexpected", {63'd0, done8}, 64'd0);
            end else begin
                logic [9:0] e;
                e = exp_q8.pop_front();
                check("sum8", {56'd0, sum8}, {56'd0, e[7:0]});
                check("cout8", {63'd0, cout8}, {63'd0, e[8]});
                check("ovf8", {63'd0, ovf8}, {63'd0, e[9]});
            end
        end
        if (done16) begin
            if (exp_q16.size() == 0) begin
                check("done16_unexpected", {63'd0, done16}, 64'd0);
            end else begin
                logic [17:0] e;
                e = exp_q16.pop_front();
                check("sum16", {48'd0, sum16}, {48'd0, e[15:0]});
                check("cout16", {63'd0, cout16}, {63'd0, e[16]});
                check("ovf16", {63'd0, ovf16}, {63'd0, e[17]});
            end
        end
    end

    // Counts negedges from the start-sampling edge until done (bounded).
    task automatic wait_done8(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done8) break;
            if (busy8) busy_n++;
        end
    endtask

    task automatic issue8(input logic [7:0] oa, input logic [7:0] ob, input logic osub,
                          input logic [9:0] e);
        @(negedge clk);
        a8 = oa; b8 = ob; sub8 = osub; start8 = 1'b1;
        exp_q8.push_back(e);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic op8(input string tag, input logic [7:0] oa, input logic [7:0] ob,
                       input logic osub, input logic [9:0] e);
        int n, bn;
        issue8(oa, ob, osub, e);
        wait_done8(n, bn);
        check({tag, "_latency"}, n, 9);
        check({tag, "_busy_cycles"}, bn, 8);
        @(negedge clk);
        check({tag, "_done_single"}, {63'd0, done8}, 64'd0);
        check({tag, "_idle_busy"}, {63'd0, busy8}, 64'd0);
    endtask

    task automatic op16(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                        input logic osub, input logic [17:0] e);
        int n;
        @(negedge clk);
        a16 = oa; b16 = ob; sub16 = osub; start16 = 1'b1;
        exp_q16.push_back(e);
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done16) break;
        end
        check({tag, "_latency"}, n, 17);
        @(negedge clk);
    endtask

    initial begin
        int n, bn;
        logic [65:0] m;
        logic [7:0] ra, rb;
        logic rs;

        #1;
        check("rst_busy8", {63'd0, busy8}, 64'd0);
        check("rst_done8", {63'd0, done8}, 64'd0);
        check("rst_sum8", {56'd0, sum8}, 64'd0);
        check("rst_cout_ovf8", {62'd0, cout8, ovf8}, 64'd0);
        check("rst_sum16", {48'd0, sum16}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        op8("add_3c_45", 8'h3C, 8'h45, 1'b0, {1'b1, 1'b0, 8'h81});
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
        op8("sub_10_20", 8'h10, 8'h20, 1'b1, {1'b0, 1'b0, 8'hF0});
        op8("sub_80_01", 8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F});

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            m = model(8, {56'd0, ra}, {56'd0, rb}, rs);
            op8("rand8", ra, rb, rs, {m[65], m[64], m[7:0]});
        end

        // start mid-run is ignored; then start held in the done cycle.
        issue8(8'h3C, 8'h45, 1'b0, {1'b1, 1'b0, 8'h81});
        repeat (3) @(negedge clk);
        a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n, bn);
        check("midrun_start_latency", n, 5);
        a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1; start8 = 1'b1;
        exp_q8.push_back({1'b1, 1'b1, 8'h7F});
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8(n, bn);
        check("b2b_latency", n, 9);
        check("b2b_busy_cycles", bn, 8);
        @(negedge clk);

        // Reset mid-run: outputs clear without a clock edge.
        issue8(8'h55, 8'h0F, 1'b0, {1'b0, 1'b0, 8'h64});
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q8.delete();
        check("abort_busy", {63'd0, busy8}, 64'd0);
        check("abort_done", {63'd0, done8}, 64'd0);
        check("abort_sum", {56'd0, sum8}, 64'd0);
        check("abort_cout_ovf", {62'd0, cout8, ovf8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy8 !== 1'b0 || i == 11) check("abort_stays_idle", {63'd0, busy8}, 64'd0);
        end

        op8("post_abort_add", 8'h01, 8'h02, 1'b0, {1'b0, 1'b0, 8'h03});

        op16("add16_7fff_1", 16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
        op16("add16_ffff_1", 16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
        op16("sub16_8000_1", 16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        for (int i = 0; i < 3; i++) begin
            logic [15:0] xa, xb;
            logic xs;
            xa = 16'($urandom_range(0, 65535));
            xb = 16'($urandom_range(0, 65535));
            xs = 1'($urandom_range(0, 1));
            m = model(16, {48'd0, xa}, {48'd0, xb}, xs);
            op16("rand16", xa, xb, xs, {m[65], m[64], m[15:0]});
        end

        repeat (2) @(negedge clk);
        check("pending8", exp_q8.size(), 0);
        check("pending16", exp_q16.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor. It is the sequential successor to the team's combinational half/full adder cells.
- Each cycle it resolves one sum bit, LSB first, using one full-adder slice plus a carry flip-flop.
- It replaces a WIDTH-bit ripple chain wherever area matters more than latency.
- A start/busy/done handshake lets a controller issue one operation at a time.

Parameters:
- WIDTH, 8: operand and result width in bits. Legal values are 2 to 64.
- CNT_W, $clog2(WIDTH+1): width of the internal bit counter. Derived; do not override.

Ports:
- clk  input  1  Single system clock. All state updates on the rising edge.
- rst  input  1  Reset, asynchronous, active-high. Clears all state immediately.
- start  input  1  Request a new operation. Sampled only while the block is idle or done.
- sub  input  1  Mode, sampled with start. 0 means A+B; 1 means A−B.
- a  input  WIDTH  Operand A, sampled with start.
- b  input  WIDTH  Operand B, sampled with start.
- busy  output  1  High while an operation is in progress.
- done  output  1  Single-cycle pulse: the result registers have just been updated.
- sum  output  WIDTH  Result of the last completed operation, held until the next completion.
- cout  output  1  Carry out of the MSB. In subtract mode, 1 means no borrow (a ≥ b unsigned).
- ovf  output  1  Two's-complement signed overflow of the last completed operation.

Behaviour:
- One clock domain. The only asynchronous path is rst. Reset is asynchronous and active-high.
- Reset state: FSM=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Internal operand shift registers, carry flip-flop and counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1 at edge k:
  - Latch a into the A shift register.
  - Latch b^{WIDTH{sub}} into the B shift register.
  - Set carry = sub and counter = 0. Go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - Compute s = a0^b0^c and c' = a0&b0 | c&(a0^b0).
  - Shift s into the MSB of the partial-sum register. Shift A and B right by one.
  - Carry <= c', counter <= counter+1.
  - On the edge where counter == WIDTH−1, capture the carry into the MSB (c_in_msb) for overflow, then go to DONE.
- Entering DONE (edge k+WIDTH):
  - sum <= completed partial sum.
  - cout <= final carry.
  - ovf <= c_in_msb ^ final carry.
  - done=1 for exactly one cycle.
- DONE behaves like IDLE for start. start=1 goes to RUN with the same latching (back-to-back operation); otherwise go to IDLE.
- busy = (state == RUN), i.e. high from the cycle after edge k through edge k+WIDTH.
- Latency: the result is visible and done is high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start while busy is ignored. Operands and mode of the running operation are unaffected.
- a, b and sub may change freely after the sampling edge.
- sum, cout and ovf change only on entry to DONE or on reset. Partial results are never visible on the outputs.
- rst asserted mid-RUN aborts immediately to the reset state with no done pulse. The first start after release begins a fresh operation.
- All arithmetic is modulo 2^WIDTH. Operands are treated as unsigned for cout and as two's complement for ovf.

Test Plan:
- Reset, then WIDTH=8, a=0x3C, b=0x45, sub=0:
  - busy is high for 8 cycles.
  - done pulses once, 9 edges after start is sampled.
  - sum=0x81, cout=0, ovf=1.
- a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1, ovf=0.
- a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0, ovf=0.
- a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
- start pulsed mid-RUN with a=0x00, b=0x00:
  - The result is still from the original operands.
  - No extra done pulse occurs.
  - Then start held high during the done cycle → a second operation starts immediately and its done arrives exactly 9 cycles later.
- Reset mid-operation:
  - rst asserted at RUN bit 4, with no clock edge → busy, sum and done read 0 immediately.
  - After release with no start, the block stays IDLE.
- Re-run the sum and overflow cases with WIDTH=16 and operands 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0, done after 17 edges.
